commit_mem_sequencer: RTL

COMMIT_MEM_SEQUENCER -- requirements
Module: commit_mem_sequencer

---
 rtl/commit_mem_sequencer_if.sv | 39 +++
 rtl/commit_mem_sequencer.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/commit_mem_sequencer_if.sv
// Memory-side request bus of the commit sequencer.
// Groups the dmem, dcache and icache request/payload lines with their addr_ok
// acknowledgements. master = sequencer side, slave = memory side.
interface commit_mem_sequencer_if;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    logic              dmem_req;
    logic              dmem_wt;
    logic [ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wd;
    logic [1:0]        dmem_size;
    logic [3:0]        dmem_write_en;
    logic              dmem_addr_ok;

    logic              dcache_req;
    logic [ADDR_W-1:0] dcache_addr;
    logic [2:0]        dcache_func;
    logic              dcache_addr_ok;

    logic              icache_req;
    logic [ADDR_W-1:0] icache_addr;
    logic [2:0]        icache_func;
    logic              icache_addr_ok;

    modport master (
        output dmem_req, dmem_wt, dmem_addr, dmem_wd, dmem_size, dmem_write_en,
        output dcache_req, dcache_addr, dcache_func,
        output icache_req, icache_addr, icache_func,
        input  dmem_addr_ok, dcache_addr_ok, icache_addr_ok
    );

    modport slave (
        input  dmem_req, dmem_wt, dmem_addr, dmem_wd, dmem_size, dmem_write_en,
        input  dcache_req, dcache_addr, dcache_func,
        input  icache_req, icache_addr, icache_func,
        output dmem_addr_ok, dcache_addr_ok, icache_addr_ok
    );
endinterface

// File: rtl/commit_mem_sequencer.sv
// Commit memory sequencer: latches a two-slot commit bundle and issues the
// older slot (1) then slot (0) to dmem / dcache / icache, one handshake each,
// then pulses done. A watchdog counter flags a sticky timeout on long stalls.
// Ports:
//   clk, reset (sync, active-low)
//   flush, valid, hold            - control inputs
//   kind/addr/wd/size/wstrb/wt/func - per-slot bundle fields, [1] is older
//   mem                           - request bus (master side)
//   busy, done, timeout           - status
module commit_mem_sequencer #(
    parameter int unsigned TMO_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            valid,
    input  logic [1:0][1:0] kind,
    input  logic [1:0][31:0] addr,
    input  logic [1:0][31:0] wd,
    input  logic [1:0][1:0] size,
    input  logic [1:0][3:0] wstrb,
    input  logic [1:0]      wt,
    input  logic [1:0][2:0] func,
    input  logic            hold,
    commit_mem_sequencer_if.master mem,
    output logic            busy,
    output logic            done,
    output logic            timeout
);
    localparam logic [1:0]       KIND_NONE = 2'b00;
    localparam logic [1:0]       KIND_DMEM = 2'b01;
    localparam logic [1:0]       KIND_DC   = 2'b10;
    localparam logic [1:0]       KIND_IC   = 2'b11;
    localparam logic [TMO_W-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {IDLE, ISS1, ISS0, DONE} state_t;

    state_t           state, state_next;
    logic [1:0][1:0]  kind_q;
    logic [1:0][31:0] addr_q, wd_q;
    logic [1:0][1:0]  size_q;
    logic [1:0][3:0]  wstrb_q;
    logic [1:0]       wt_q;
    logic [1:0][2:0]  func_q;
    logic [TMO_W-1:0] cnt, cnt_next;
    logic             tmo_next;
    logic             in_iss, slot, handshake;
    logic             dreq, creq, ireq;
    logic [1:0]       kind_sel;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Bundle latch, watchdog counter and sticky timeout
    always_ff @(posedge clk) begin
        if (!reset) begin
            kind_q  <= '0;
            addr_q  <= '0;
            wd_q    <= '0;
            size_q  <= '0;
            wstrb_q <= '0;
            wt_q    <= '0;
            func_q  <= '0;
            cnt     <= '0;
            timeout <= 1'b0;
        end else begin
            cnt     <= cnt_next;
            timeout <= tmo_next;
            if (state == IDLE && valid && !flush) begin
                kind_q  <= kind;
                addr_q  <= addr;
                wd_q    <= wd;
                size_q  <= size;
                wstrb_q <= wstrb;
                wt_q    <= wt;
                func_q  <= func;
            end
        end
    end

    // Next state, request decode and payload mux
    always_comb begin
        state_next         = state;
        dreq               = 1'b0;
        creq               = 1'b0;
        ireq               = 1'b0;
        cnt_next           = cnt;
        tmo_next           = timeout;
        mem.dmem_wt        = 1'b0;
        mem.dmem_addr      = '0;
        mem.dmem_wd        = '0;
        mem.dmem_size      = '0;
        mem.dmem_write_en  = '0;
        mem.dcache_addr    = '0;
        mem.dcache_func    = '0;
        mem.icache_addr    = '0;
        mem.icache_func    = '0;

        in_iss   = reset && (state == ISS1 || state == ISS0);
        slot     = (state == ISS1);
        kind_sel = kind_q[slot];

        if (in_iss) begin
            mem.dmem_wt       = wt_q[slot];
            mem.dmem_addr     = addr_q[slot];
            mem.dmem_wd       = wd_q[slot];
            mem.dmem_size     = size_q[slot];
            mem.dmem_write_en = wstrb_q[slot];
            mem.dcache_addr   = addr_q[slot];
            mem.dcache_func   = func_q[slot];
            mem.icache_addr   = addr_q[slot];
            mem.icache_func   = func_q[slot];
        end

        // hold only stalls the data side; flush kills everything
        if (in_iss && !flush) begin
            dreq = !hold && kind_sel == KIND_DMEM;
            creq = !hold && kind_sel == KIND_DC;
            ireq = kind_sel == KIND_IC;
        end
        handshake = (dreq && mem.dmem_addr_ok) || (creq && mem.dcache_addr_ok)
                 || (ireq && mem.icache_addr_ok);

        mem.dmem_req   = dreq;
        mem.dcache_req = creq;
        mem.icache_req = ireq;
        busy = reset && state != IDLE;
        done = reset && state == DONE;

        case (state)
            IDLE: if (valid) begin
                if (kind[1] != KIND_NONE)      state_next = ISS1;
                else if (kind[0] != KIND_NONE) state_next = ISS0;
                else                           state_next = DONE;
            end
            ISS1: if (handshake) state_next = (kind_q[0] != KIND_NONE) ? ISS0 : DONE;
            ISS0: if (handshake) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush) state_next = IDLE;

        // Counter restarts on any state change or handshake, saturates otherwise
        if (state_next != state || handshake) cnt_next = '0;
        else if (in_iss && cnt != CNT_MAX)    cnt_next = cnt + TMO_W'(1);
        if (cnt_next == CNT_MAX) tmo_next = 1'b1;
    end
endmodule
